// File: rtl/matvec_pkg.sv
// matvec_pkg: shared types for the matrix-vector sequencer.
// State encoding, CSR bit positions and latched dimension bundle.
package matvec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } state_t;

  localparam int CFG_START = 15;
  localparam int CFG_ABORT = 14;
  localparam int CFG_CLR   = 13;

  typedef struct packed {
    logic [3:0] rows_m1;
    logic [3:0] cols_m1;
  } cfg_t;

endpackage

// File: rtl/matvec_mac.sv
// matvec_mac: registered signed MAC; res is the next accumulator value,
// clamped at zero when MATVEC_RELU_EN is defined.
// Ports: clk, rst, en, first, a, b (DATA_W) -> res (ACC_W).
module matvec_mac
  import matvec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              first,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  res
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_nxt;

  always_comb begin
    prod     = $signed(a) * $signed(b);
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    acc_nxt  = (first ? '0 : acc_q) + prod_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_nxt;
    end
  end

  // The sum is exposed before it is registered so the row result can
  // be loaded in the same cycle as the final accumulate.
`ifdef MATVEC_RELU_EN
  assign res = acc_nxt[ACC_W-1] ? '0 : acc_nxt;
`else
  assign res = acc_nxt;
`endif

endmodule

// File: rtl/matvec_sequencer.sv
// matvec_sequencer: computes y = M*x row by row from matrix/vector SRAMs.
// Ports: clk, rst, cfg_data/cfg_valid (CSR word), mat_*/vec_* SRAM reads,
// res_data/res_row/res_valid/res_ready result handshake, status.
// Optional: MATVEC_RELU_EN clamps negative row results to zero.
module matvec_sequencer
  import matvec_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24,
  parameter int DIM_W      = 4,
  parameter int MAT_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           cfg_data,
  input  logic                  cfg_valid,
  output logic [MAT_ADDR_W-1:0] mat_raddr,
  output logic                  mat_ren,
  input  logic [DATA_W-1:0]     mat_rdata,
  output logic [DIM_W-1:0]      vec_raddr,
  output logic                  vec_ren,
  input  logic [DATA_W-1:0]     vec_rdata,
  output logic [ACC_W-1:0]      res_data,
  output logic [DIM_W-1:0]      res_row,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [15:0]           status
);

  state_t           state;
  cfg_t             dims;
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] rows_m1;
  logic [DIM_W-1:0] cols_m1;
  logic             busy;
  logic             done;
  logic             rd_v;
  logic             rd_first;
  logic [ACC_W-1:0] mac_res;
  logic             start;
  logic             abort;
  logic             clr;
  logic             unused_cfg;

  assign start      = cfg_valid & cfg_data[CFG_START];
  assign abort      = cfg_valid & cfg_data[CFG_ABORT];
  assign clr        = cfg_valid & cfg_data[CFG_CLR];
  assign unused_cfg = ^cfg_data[12:8];

  assign rows_m1 = DIM_W'(dims.rows_m1);
  assign cols_m1 = DIM_W'(dims.cols_m1);

  assign mat_raddr = MAT_ADDR_W'({row, col});
  assign vec_raddr = col;
  assign vec_ren   = mat_ren;
  assign status    = {busy, done, 6'b0, 8'(row)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dims      <= '0;
      row       <= '0;
      col       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mat_ren   <= 1'b0;
      rd_v      <= 1'b0;
      rd_first  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
    end else begin
      // Tag travels with the read into the MAC stage.
      rd_v     <= mat_ren;
      rd_first <= (col == '0);
      unique case (state)
        IDLE: begin
          if (start) begin
            dims    <= cfg_t'(cfg_data[7:0]);
            row     <= '0;
            col     <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
            mat_ren <= 1'b1;
            state   <= ISSUE;
          end else if (clr) begin
            done <= 1'b0;
          end
        end
        ISSUE: begin
          if (abort) begin
            mat_ren <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (col == cols_m1) begin
            mat_ren <= 1'b0;
            state   <= DRAIN;
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            res_data  <= mac_res;
            res_row   <= row;
            res_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (abort) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            if (row == rows_m1) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              row     <= row + 1'b1;
              col     <= '0;
              mat_ren <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  matvec_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (rd_v),
    .first(rd_first),
    .a    (mat_rdata),
    .b    (vec_rdata),
    .res  (mac_res)
  );

endmodule

// File: doc/matvec_sequencer.md
Name: matvec_sequencer

Overview:
- Sequences one matrix-vector product y = M·x for the SPI-controlled matrix accelerator.
- Configured and started by the general CSR word that the CSR decoder emits on csr_if.
- Walks the matrix and vector SRAMs row by row and accumulates each row's dot product.
- Hands each row result to the result buffer / bus_2_spi readback path through a valid/ready handshake.

Parameters:
- DATA_W, 8, signed element width of matrix and vector words
- ACC_W, 24, signed accumulator and result width
- DIM_W, 4, dimension counter width; max rows = max cols = 2**DIM_W
- MAT_ADDR_W, 8, matrix SRAM address width, must be ≥ 2*DIM_W

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cfg_data  in  16  general CSR word: [15] start, [14] abort, [13] clear_done, [7:4] rows_m1, [3:0] cols_m1
- cfg_valid  in  1  cfg_data qualifier; a word is accepted on each clk where it is high
- mat_raddr  out  MAT_ADDR_W  matrix SRAM read address, row-major, = row*2**DIM_W + col
- mat_ren  out  1  matrix read enable
- mat_rdata  in  DATA_W  matrix read data, valid the cycle after mat_ren
- vec_raddr  out  DIM_W  vector SRAM read address, = col
- vec_ren  out  1  vector read enable, always equal to mat_ren
- vec_rdata  in  DATA_W  vector read data, valid the cycle after vec_ren
- res_data  out  ACC_W  row result
- res_row  out  DIM_W  row index of res_data
- res_valid  out  1  result handshake valid
- res_ready  in  1  result handshake ready
- status  out  16  {busy, done, 6'b0, cur_row[DIM_W-1:0] zero-extended to 8}

Behaviour:
- Reset (async, rst=1): state IDLE; all counters, accumulator and addresses 0; mat_ren=vec_ren=0; res_valid=0; res_data=0; res_row=0; done=0; busy=0.
- Config capture:
  - rows_m1/cols_m1 are latched only when start is accepted.
  - Dimensions 1..2**DIM_W. rows_m1=cols_m1=0 means a 1x1 product.
- IDLE:
  - cfg_valid & start: latch dims, clear done, clear row/col, next state ISSUE.
  - clear_done alone clears done.
  - start together with clear_done: start wins, done=0.
  - abort is ignored.
- ISSUE (busy=1):
  - Each cycle: mat_ren=vec_ren=1 at (row,col); col increments.
  - col==cols_m1: next state DRAIN.
  - Pipeline tag (first, last) is registered alongside the read.
- MAC stage (one cycle after each read):
  - acc = (first ? 0 : acc) + sign_ext(mat_rdata*vec_rdata).
  - Product is a full 2*DATA_W signed value; sum wraps modulo 2**ACC_W, no saturation.
- DRAIN: wait one cycle for the last accumulate, then load res_data=acc and res_row=row, set res_valid=1, next state OUT.
- OUT:
  - Hold res_data, res_row and res_valid stable until res_valid & res_ready.
  - On handshake: res_valid=0.
  - If row==rows_m1: set done=1, next state IDLE.
  - Otherwise: row+1, col=0, next state ISSUE.
- Latency per row: first read in cycle 0, res_valid high in cycle C+1 (C = cols). Each row costs at least C+2 cycles.
- With res_ready tied high the whole product takes R*(C+2) cycles after the start-accept cycle.
- Start while busy: ignored, no effect on counters or latched dims.
- abort while busy:
  - Next state IDLE, res_valid=0, reads stop the same cycle, done not set.
  - A partially accumulated row is discarded.
- Address wrap: col and row never exceed the latched maxima; counters do not wrap past rows_m1/cols_m1.
- status is registered and reflects state the cycle after each change. done is sticky.
- rst asserted mid-operation: immediate return to reset values; no result is emitted.

Optional Feature:
- Macro: MATVEC_RELU_EN.
- Defined: the value loaded into res_data in DRAIN is max(acc, 0); negative results become 0.
- Undefined: res_data = acc unmodified. Ports and timing are identical in both builds.

Decomposition:
- Package matvec_pkg:
  - state enum (IDLE, ISSUE, DRAIN, OUT)
  - cfg field bit-position constants CFG_START=15, CFG_ABORT=14, CFG_CLR=13
  - cfg_t packed struct for rows_m1/cols_m1
- One natural sub-module, matvec_mac: registered multiply-accumulate with first/en inputs and the optional ReLU output stage.

Test Plan:
- 2x3, M={1,2,3; -4,5,-6}, x={1,1,2}, res_ready=1 -> res (row0,9) then (row1,-11); done=1; total 10 cycles after accept.
- Same stimulus with MATVEC_RELU_EN defined -> row0=9, row1=0.
- 1x1, M=-128, x=-128 -> res 16384, sign correct. 16x16 all 127·127 -> every row = 258064, mat_raddr reaches 255.
- res_ready low 5 cycles on row0 -> res_valid/data/row held stable; no new mat_ren until handshake; row1 follows.
- abort in ISSUE of row1 -> mat_ren=0 next cycle, IDLE, done=0; a start during busy is ignored; start+clear_done in IDLE -> starts with done=0.
- rst pulsed mid-ISSUE -> all outputs 0 asynchronously; a new start afterwards produces correct results.
